// File: rtl/mcb_cmd_fe.sv
// Host-side front end for a memory controller back end: queues commands and write beats,
// issues one command strobe per three cycles, and registers returning read data.
module mcb_cmd_fe #(
  parameter int unsigned MCB_B_W    = 2,
  parameter int unsigned MCB_R_W    = 13,
  parameter int unsigned MCB_C_W    = 9,
  parameter int unsigned MCB_D_W    = 32,
  parameter int unsigned MCB_BE_W   = 4,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned WDAT_DEPTH = 16
) (
  input  logic                               mcb_clk,
  input  logic                               mcb_rst,
  input  logic                               hst_req_vld,
  output logic                               hst_req_rdy,
  input  logic                               hst_wr_n,
  input  logic                               hst_bl,
  input  logic [MCB_B_W+MCB_R_W+MCB_C_W-1:0] hst_addr,
  input  logic                               hst_wdat_vld,
  output logic                               hst_wdat_rdy,
  input  logic [MCB_D_W-1:0]                 hst_wdat,
  input  logic [MCB_BE_W-1:0]                hst_wbe,
  output logic                               hst_rdat_vld,
  output logic [MCB_D_W-1:0]                 hst_rdat,
  output logic                               fe_err,
  input  logic                               mcb_i_ready,
  input  logic                               mcb_busy,
  output logic                               mcb_bb,
  output logic                               mcb_wr_n,
  output logic [1:0]                         mcb_bl,
  output logic [MCB_B_W-1:0]                 mcb_ba,
  output logic [MCB_R_W-1:0]                 mcb_ra,
  output logic [MCB_C_W-1:0]                 mcb_ca,
  input  logic                               mcb_wdat_req,
  output logic [MCB_D_W-1:0]                 mcb_wdat,
  output logic [MCB_BE_W-1:0]                mcb_wbe,
  input  logic                               mcb_rdat_vld,
  input  logic [MCB_D_W-1:0]                 mcb_rdat
);

  localparam int unsigned AW   = MCB_B_W + MCB_R_W + MCB_C_W;
  localparam int unsigned CE_W = AW + 2;
  localparam int unsigned WE_W = MCB_D_W + MCB_BE_W;
  localparam int unsigned CP_W = $clog2(CMD_DEPTH);
  localparam int unsigned CC_W = CP_W + 1;
  localparam int unsigned WP_W = $clog2(WDAT_DEPTH);
  localparam int unsigned WC_W = WP_W + 1;
  localparam int unsigned AV_W = WC_W + 4;

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;
  state_e state_q, state_d;

  // Command FIFO
  logic [CE_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CP_W-1:0] cmd_wp_q, cmd_rp_q;
  logic [CC_W-1:0] cmd_cnt_q;
  logic            cmd_push, cmd_pop, cmd_empty, cmd_load, issue_wr;
  logic [CE_W-1:0] cmd_head;
  logic            head_wr_n, head_bl, wr_ok;
  logic [AW-1:0]   head_addr;
  logic [3:0]      head_beats;

  assign hst_req_rdy = (cmd_cnt_q != CC_W'(CMD_DEPTH));
  assign cmd_push    = hst_req_vld && hst_req_rdy;
  assign cmd_empty   = (cmd_cnt_q == '0);
  assign cmd_head    = cmd_mem[cmd_rp_q];
  assign head_wr_n   = cmd_head[CE_W-1];
  assign head_bl     = cmd_head[CE_W-2];
  assign head_addr   = cmd_head[AW-1:0];
  assign head_beats  = head_bl ? 4'd8 : 4'd4;

  always_ff @(posedge mcb_clk) begin
    if (cmd_push) cmd_mem[cmd_wp_q] <= {hst_wr_n, hst_bl, hst_addr};
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (cmd_push) cmd_wp_q <= cmd_wp_q + CP_W'(1);
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + CP_W'(1);
      cmd_cnt_q <= cmd_cnt_q + CC_W'(cmd_push) - CC_W'(cmd_pop);
    end
  end

  // Write-data FIFO (first-word-fall-through)
  logic [WE_W-1:0] wdat_mem [WDAT_DEPTH];
  logic [WP_W-1:0] wdat_wp_q, wdat_rp_q;
  logic [WC_W-1:0] wdat_cnt_q, committed_q, committed_d;
  logic            wdat_push, wdat_pop, wdat_empty;
  logic [AV_W-1:0] commit_sum;

  assign hst_wdat_rdy = (wdat_cnt_q != WC_W'(WDAT_DEPTH));
  assign wdat_push    = hst_wdat_vld && hst_wdat_rdy;
  assign wdat_empty   = (wdat_cnt_q == '0);
  assign wdat_pop     = mcb_wdat_req && !wdat_empty;
  assign {mcb_wdat, mcb_wbe} = wdat_empty ? '0 : wdat_mem[wdat_rp_q];

  always_ff @(posedge mcb_clk) begin
    if (wdat_push) wdat_mem[wdat_wp_q] <= {hst_wdat, hst_wbe};
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      wdat_wp_q  <= '0;
      wdat_rp_q  <= '0;
      wdat_cnt_q <= '0;
    end else begin
      if (wdat_push) wdat_wp_q <= wdat_wp_q + WP_W'(1);
      if (wdat_pop)  wdat_rp_q <= wdat_rp_q + WP_W'(1);
      wdat_cnt_q <= wdat_cnt_q + WC_W'(wdat_push) - WC_W'(wdat_pop);
    end
  end

  // Beats promised to issued writes; an issue and a consume in one cycle net out here.
  always_comb begin
    commit_sum = AV_W'(committed_q) + (issue_wr ? AV_W'(head_beats) : '0);
    if (mcb_wdat_req && (commit_sum != '0)) commit_sum = commit_sum - AV_W'(1);
    committed_d = commit_sum[WC_W-1:0];
  end

  assign wr_ok = head_wr_n || (AV_W'(wdat_cnt_q) >= AV_W'(committed_q) + AV_W'(head_beats));

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      committed_q <= '0;
      fe_err      <= 1'b0;
    end else begin
      committed_q <= committed_d;
      if (mcb_wdat_req && wdat_empty) fe_err <= 1'b1;
    end
  end

  // Issue FSM
  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!cmd_empty && mcb_i_ready && !mcb_busy && wr_ok) state_d = StIssue;
      StIssue: state_d = StHold;
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mcb_bb   = (state_q == StIssue) && !mcb_rst;
    cmd_pop  = (state_q == StIssue);
    issue_wr = cmd_pop && !head_wr_n;
    cmd_load = (state_q == StIdle) && (state_d == StIssue);
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      mcb_wr_n <= 1'b1;
      mcb_bl   <= 2'b00;
      mcb_ba   <= '0;
      mcb_ra   <= '0;
      mcb_ca   <= '0;
    end else if (cmd_load) begin
      mcb_wr_n <= head_wr_n;
      mcb_bl   <= {1'b0, head_bl};
      {mcb_ba, mcb_ra, mcb_ca} <= head_addr;
    end
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      hst_rdat_vld <= 1'b0;
      hst_rdat     <= '0;
    end else begin
      hst_rdat_vld <= mcb_rdat_vld;
      hst_rdat     <= mcb_rdat;
    end
  end

endmodule

// File: tb/tb_mcb_cmd_fe.sv
// Directed bench for mcb_cmd_fe: command issue, write-data flow, backpressure, error flag,
// read path and mid-burst reset.
module tb_mcb_cmd_fe;

  logic        clk = 1'b0;
  logic        mcb_rst, hst_req_vld, hst_req_rdy, hst_wr_n, hst_bl;
  logic [23:0] hst_addr;
  logic        hst_wdat_vld, hst_wdat_rdy;
  logic [31:0] hst_wdat;
  logic [3:0]  hst_wbe;
  logic        hst_rdat_vld;
  logic [31:0] hst_rdat;
  logic        fe_err, mcb_i_ready, mcb_busy, mcb_bb, mcb_wr_n;
  logic [1:0]  mcb_bl;
  logic [1:0]  mcb_ba;
  logic [12:0] mcb_ra;
  logic [8:0]  mcb_ca;
  logic        mcb_wdat_req;
  logic [31:0] mcb_wdat;
  logic [3:0]  mcb_wbe;
  logic        mcb_rdat_vld;
  logic [31:0] mcb_rdat;

  always #5 clk = ~clk;

  mcb_cmd_fe dut (
    .mcb_clk(clk), .mcb_rst(mcb_rst),
    .hst_req_vld(hst_req_vld), .hst_req_rdy(hst_req_rdy), .hst_wr_n(hst_wr_n),
    .hst_bl(hst_bl), .hst_addr(hst_addr),
    .hst_wdat_vld(hst_wdat_vld), .hst_wdat_rdy(hst_wdat_rdy), .hst_wdat(hst_wdat),
    .hst_wbe(hst_wbe), .hst_rdat_vld(hst_rdat_vld), .hst_rdat(hst_rdat), .fe_err(fe_err),
    .mcb_i_ready(mcb_i_ready), .mcb_busy(mcb_busy), .mcb_bb(mcb_bb), .mcb_wr_n(mcb_wr_n),
    .mcb_bl(mcb_bl), .mcb_ba(mcb_ba), .mcb_ra(mcb_ra), .mcb_ca(mcb_ca),
    .mcb_wdat_req(mcb_wdat_req), .mcb_wdat(mcb_wdat), .mcb_wbe(mcb_wbe),
    .mcb_rdat_vld(mcb_rdat_vld), .mcb_rdat(mcb_rdat)
  );

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int nlog = 0;
  logic [26:0] log_cmd [16];
  int          log_cyc [16];
  logic [23:0] addr_q [5];
  logic [31:0] exp_d;
  logic [3:0]  exp_be;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and strobes are logged.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mcb_bb === 1'b1) begin
      if (nlog < 16) begin
        log_cmd[nlog] = {mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca};
        log_cyc[nlog] = cyc;
      end
      nlog++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    mcb_rst = 1'b1; hst_req_vld = 1'b0; hst_wr_n = 1'b1; hst_bl = 1'b0; hst_addr = '0;
    hst_wdat_vld = 1'b0; hst_wdat = '0; hst_wbe = '0; mcb_i_ready = 1'b0; mcb_busy = 1'b0;
    mcb_wdat_req = 1'b0; mcb_rdat_vld = 1'b0; mcb_rdat = '0;
    tick();
    tick();
    chk("rst_bb", 64'(mcb_bb), 64'd0);
    chk("rst_wr_n", 64'(mcb_wr_n), 64'd1);
    chk("rst_bl", 64'(mcb_bl), 64'd0);
    chk("rst_addr", 64'({mcb_ba, mcb_ra, mcb_ca}), 64'd0);
    chk("rst_rdat_vld", 64'(hst_rdat_vld), 64'd0);
    chk("rst_fe_err", 64'(fe_err), 64'd0);
    mcb_rst = 1'b0;
    tick();
    chk("rst_req_rdy", 64'(hst_req_rdy), 64'd1);
    chk("rst_wdat_rdy", 64'(hst_wdat_rdy), 64'd1);

    // Read4 at address 0 held off until the back end is initialised
    nlog = 0;
    hst_req_vld = 1'b1; hst_wr_n = 1'b1; hst_bl = 1'b0; hst_addr = '0;
    tick();
    hst_req_vld = 1'b0;
    repeat (4) tick();
    chk("init_hold_no_bb", 64'(nlog), 64'd0);
    mcb_i_ready = 1'b1;
    repeat (5) tick();
    chk("init_bb_count", 64'(nlog), 64'd1);
    chk("init_cmd", 64'(log_cmd[0]), 64'({1'b1, 2'b00, 24'h0}));

    // Write8 {ba=1,ra=25,ca=96}: no issue until the eighth beat is queued
    nlog = 0;
    hst_req_vld = 1'b1; hst_wr_n = 1'b0; hst_bl = 1'b1;
    hst_addr = {2'd1, 13'd25, 9'd96};
    for (int i = 0; i < 7; i++) begin
      hst_wdat_vld = 1'b1;
      hst_wdat = 32'hD000_0000 + 32'(i) * 32'h0101_0101;
      hst_wbe = 4'(i + 1);
      tick();
      hst_req_vld = 1'b0;
    end
    hst_wdat_vld = 1'b0;
    repeat (4) tick();
    chk("wr7_no_bb", 64'(nlog), 64'd0);
    hst_wdat_vld = 1'b1;
    hst_wdat = 32'hD000_0000 + 32'd7 * 32'h0101_0101;
    hst_wbe = 4'd8;
    tick();
    hst_wdat_vld = 1'b0;
    repeat (5) tick();
    chk("wr8_bb_count", 64'(nlog), 64'd1);
    chk("wr8_cmd", 64'(log_cmd[0]), 64'({1'b0, 2'b01, 2'd1, 13'd25, 9'd96}));
    chk("wr8_hold_bl", 64'(mcb_bl), 64'd1);
    for (int i = 0; i < 8; i++) begin
      mcb_wdat_req = 1'b1;
      exp_d = 32'hD000_0000 + 32'(i) * 32'h0101_0101;
      exp_be = 4'(i + 1);
      chk($sformatf("wbeat%0d", i), 64'({mcb_wdat, mcb_wbe}), 64'({exp_d, exp_be}));
      tick();
    end
    mcb_wdat_req = 1'b0;
    chk("wr8_no_err", 64'(fe_err), 64'd0);

    // Five reads against a busy back end: the fifth is refused, four drain in order
    nlog = 0;
    mcb_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      addr_q[i] = {2'(i), 13'(i * 3 + 1), 9'(i + 5)};
      hst_req_vld = 1'b1; hst_wr_n = 1'b1; hst_bl = 1'(i % 2); hst_addr = addr_q[i];
      chk($sformatf("full_rdy%0d", i), 64'(hst_req_rdy), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    hst_req_vld = 1'b0;
    chk("busy_no_bb", 64'(nlog), 64'd0);
    mcb_busy = 1'b0;
    repeat (20) tick();
    chk("drain_count", 64'(nlog), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_cmd%0d", i), 64'(log_cmd[i]),
          64'({1'b1, 1'b0, 1'(i % 2), addr_q[i]}));
    for (int i = 1; i < 4; i++)
      chk($sformatf("drain_gap%0d", i), 64'(log_cyc[i] - log_cyc[i-1] >= 3), 64'd1);
    chk("drain_rdy", 64'(hst_req_rdy), 64'd1);

    // Write-data underflow
    mcb_wdat_req = 1'b1;
    chk("uflow_zero_data", 64'({mcb_wdat, mcb_wbe}), 64'd0);
    chk("uflow_err_before", 64'(fe_err), 64'd0);
    tick();
    mcb_wdat_req = 1'b0;
    chk("uflow_err_set", 64'(fe_err), 64'd1);
    repeat (3) tick();
    chk("uflow_err_sticky", 64'(fe_err), 64'd1);

    // Read-data path, one-cycle latency
    mcb_rdat_vld = 1'b1; mcb_rdat = 32'hA5A5_A5A5;
    chk("rd_pre_vld", 64'(hst_rdat_vld), 64'd0);
    tick();
    mcb_rdat = 32'h5A5A_1234;
    chk("rd_vld0", 64'(hst_rdat_vld), 64'd1);
    chk("rd_dat0", 64'(hst_rdat), 64'hA5A5_A5A5);
    tick();
    mcb_rdat_vld = 1'b0; mcb_rdat = '0;
    chk("rd_dat1", 64'(hst_rdat), 64'h5A5A_1234);
    tick();
    chk("rd_vld_off", 64'(hst_rdat_vld), 64'd0);

    // Reset while in HOLD with two commands still queued
    nlog = 0;
    for (int i = 0; i < 3; i++) begin
      hst_req_vld = 1'b1; hst_wr_n = 1'b1; hst_bl = 1'b1;
      hst_addr = 24'h5A_0100 + 24'(i);
      tick();
    end
    hst_req_vld = 1'b0;
    chk("pre_rst_count", 64'(nlog), 64'd1);
    chk("pre_rst_cmd", 64'(log_cmd[0]), 64'({1'b1, 2'b01, 24'h5A_0100}));
    mcb_rst = 1'b1;
    chk("rst_cycle_bb", 64'(mcb_bb), 64'd0);
    tick();
    chk("mid_rst_bb", 64'(mcb_bb), 64'd0);
    chk("mid_rst_wr_n", 64'(mcb_wr_n), 64'd1);
    chk("mid_rst_bl", 64'(mcb_bl), 64'd0);
    chk("mid_rst_addr", 64'({mcb_ba, mcb_ra, mcb_ca}), 64'd0);
    chk("mid_rst_fe_err", 64'(fe_err), 64'd0);
    chk("mid_rst_rdat", 64'({hst_rdat_vld, hst_rdat}), 64'd0);
    mcb_rst = 1'b0;
    tick();
    chk("post_rst_req_rdy", 64'(hst_req_rdy), 64'd1);
    chk("post_rst_wdat_rdy", 64'(hst_wdat_rdy), 64'd1);
    repeat (10) tick();
    chk("post_rst_no_bb", 64'(nlog), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mcb_cmd_fe.md
MCB_CMD_FE -- requirements
Module: mcb_cmd_fe

Interface
REQ-001 SHALL have parameter MCB_B_W, default 2, meaning bank address width.
REQ-002 SHALL have parameter MCB_R_W, default 13, meaning row address width.
REQ-003 SHALL have parameter MCB_C_W, default 9, meaning column address width.
REQ-004 SHALL have parameter MCB_D_W, default 32, meaning data width; MCB_BE_W, default 4, meaning byte-enable width.
REQ-005 SHALL have parameter CMD_DEPTH, default 4, meaning command FIFO entries; WDAT_DEPTH, default 16, meaning write-data FIFO entries.
REQ-006 Ports SHALL be, one clock; reset is synchronous and active-high:
  mcb_clk  in  1  clock, all logic on rising edge
  mcb_rst  in  1  synchronous active-high reset
  hst_req_vld  in  1  host command valid
  hst_req_rdy  out  1  command FIFO not full
  hst_wr_n  in  1  0=write, 1=read
  hst_bl  in  1  0=burst 4, 1=burst 8
  hst_addr  in  MCB_B_W+MCB_R_W+MCB_C_W  linear address
  hst_wdat_vld  in  1  write beat valid
  hst_wdat_rdy  out  1  write-data FIFO not full
  hst_wdat  in  MCB_D_W  write beat
  hst_wbe  in  MCB_BE_W  write byte enables
  hst_rdat_vld  out  1  read beat valid
  hst_rdat  out  MCB_D_W  read beat
  fe_err  out  1  sticky write-data underflow
  mcb_i_ready  in  1  back-end initialization done
  mcb_busy  in  1  back-end cannot accept command
  mcb_bb  out  1  command strobe
  mcb_wr_n  out  1  command direction
  mcb_bl  out  2  2'b00=4 beats, 2'b01=8 beats
  mcb_ba / mcb_ra / mcb_ca  out  MCB_B_W / MCB_R_W / MCB_C_W  address fields
  mcb_wdat_req  in  1  back-end consumes one write beat this cycle
  mcb_wdat  out  MCB_D_W  write beat
  mcb_wbe  out  MCB_BE_W  write byte enables
  mcb_rdat_vld  in  1  read beat valid
  mcb_rdat  in  MCB_D_W  read beat

Function
REQ-007 Command push when hst_req_vld && hst_req_rdy; entry = {wr_n, bl, addr}; simultaneous push and pop when full SHALL be refused (rdy depends on registered count only).
REQ-008 Write-data push when hst_wdat_vld && hst_wdat_rdy; entry = {wdat, wbe}; first-word-fall-through.
REQ-009 Address split SHALL be {mcb_ba, mcb_ra, mcb_ca} = hst_addr, bank in MSBs.
REQ-010 Issue FSM states IDLE, ISSUE, HOLD; reset state IDLE.
REQ-011 IDLE->ISSUE when command FIFO non-empty, mcb_i_ready=1, mcb_busy=0, and for a write head, wdat_avail >= beats (4 or 8).
REQ-012 ISSUE: mcb_bb=1 for exactly one cycle with registered mcb_wr_n/mcb_bl/mcb_ba/mcb_ra/mcb_ca; command FIFO popped; -> HOLD.
REQ-013 HOLD: one mandatory cycle ignoring mcb_busy; -> IDLE. Minimum spacing between mcb_bb pulses SHALL be 3 cycles.
REQ-014 mcb_wr_n/bl/ba/ra/ca SHALL hold their last issued values outside ISSUE.
REQ-015 wdat_avail = write-FIFO count - committed; committed increments by burst beats at write ISSUE, decrements by 1 per mcb_wdat_req; both in same cycle SHALL net correctly.
REQ-016 mcb_wdat/mcb_wbe SHALL be the FIFO head combinationally; mcb_wdat_req pops one entry same cycle.
REQ-017 mcb_wdat_req with write FIFO empty SHALL set fe_err (sticky until reset), no pop, mcb_wdat=0, mcb_wbe=0.
REQ-018 hst_rdat_vld/hst_rdat SHALL be mcb_rdat_vld/mcb_rdat registered, latency 1 cycle, no backpressure.
REQ-019 FIFO pointers SHALL wrap modulo depth; depths are powers of two.

Reset
REQ-020 On mcb_rst=1 at a clock edge: FIFOs empty, committed=0, FSM IDLE, mcb_bb=0, mcb_wr_n=1, mcb_bl=0, mcb_ba/ra/ca=0, hst_rdat_vld=0, hst_rdat=0, fe_err=0; hst_req_rdy=1, hst_wdat_rdy=1 from next cycle.
REQ-021 Reset mid-burst SHALL discard all queued commands and data; no mcb_bb in the reset cycle or the cycle after.

Verification
REQ-022 mcb_i_ready=0, push read4 addr 0 -> no mcb_bb; raise mcb_i_ready -> mcb_bb one cycle, mcb_wr_n=1, mcb_bl=00, ba/ra/ca=0.
REQ-023 Push write8 {ba=1,ra=25,ca=96} plus 7 beats -> no issue; 8th beat -> mcb_bb, mcb_bl=01; 8 mcb_wdat_req pulses return beats in push order.
REQ-024 Push 5 commands back-to-back with mcb_busy=1 -> hst_req_rdy=0 after 4; release busy -> 4 pulses spaced >=3 cycles, order preserved.
REQ-025 mcb_wdat_req with empty write FIFO -> fe_err=1 next cycle, stays 1 until mcb_rst.
REQ-026 mcb_rdat_vld pulses with 0xA5A5A5A5 -> hst_rdat_vld/hst_rdat one cycle later, identical value.
REQ-027 Assert mcb_rst during HOLD with 2 queued commands -> all outputs at reset values, no further mcb_bb.
